// File: rtl/cpu_io_port.sv
// 6510 on-chip I/O port: DDR at $0000, data register at $0001, effective pin levels
// for the memory-map PLA and datasette, and the capacitive fade of floating bits 6/7.
module cpu_io_port #(
   parameter int unsigned FADE_CYCLES = 350000,
   parameter int unsigned FADE_W      = 20
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        phi2_en,
   input  logic [15:0] addr,
   input  logic        rw_n,
   input  logic [7:0]  data_in,
   input  logic [5:0]  port_in,
   output logic [7:0]  data_out,
   output logic        data_oe,
   output logic [5:0]  port_out,
   output logic [5:0]  port_oe,
   output logic        loram,
   output logic        hiram,
   output logic        charen,
   output logic        cass_wr,
   output logic        cass_motor
);

   typedef enum logic [1:0] {
      ST_DRIVEN,
      ST_FADING,
      ST_FADED
   } fade_state_e;

   localparam logic [FADE_W-1:0] CNT_LOAD = FADE_W'(FADE_CYCLES);

   logic [7:0] ddr_q, ddr_d;
   logic [7:0] dat_q, dat_d;
   logic       wr_en;
   logic [5:0] pin;
   logic [1:0] pin_hi;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ddr_q <= '0;
         dat_q <= '0;
      end else begin
         ddr_q <= ddr_d;
         dat_q <= dat_d;
      end
   end

   always_comb begin
      wr_en = phi2_en & ~rw_n;
      ddr_d = ddr_q;
      dat_d = dat_q;
      if (wr_en && addr == 16'h0000) ddr_d = data_in;
      if (wr_en && addr == 16'h0001) dat_d = data_in;
   end

   // One fade FSM per unconnected bit (6 and 7); the last driven level decays after
   // CNT_LOAD phi2 strobes once the bit becomes an input.
   for (genvar g = 0; g < 2; g++) begin : g_fade
      fade_state_e       state_q, state_d;
      logic [FADE_W-1:0] cnt_q, cnt_d;
      logic              fade_bit_q, fade_bit_d;
      logic              set_now;

      always_ff @(posedge clk) begin
         if (!rst_n) begin
            state_q    <= ST_FADED;
            cnt_q      <= '0;
            fade_bit_q <= 1'b0;
         end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            fade_bit_q <= fade_bit_d;
         end
      end

      always_comb begin
         set_now    = ddr_d[6+g] & ~ddr_q[6+g];
         state_d    = state_q;
         cnt_d      = cnt_q;
         fade_bit_d = fade_bit_q;
         unique case (state_q)
            ST_DRIVEN: begin
               fade_bit_d = dat_q[6+g];
               cnt_d      = CNT_LOAD;
               if (!ddr_d[6+g]) state_d = ST_FADING;
            end
            ST_FADING: begin
               // A DDR write that re-drives the bit wins over the same-cycle decrement.
               if (set_now) begin
                  cnt_d   = CNT_LOAD;
                  state_d = ST_DRIVEN;
               end else if (phi2_en) begin
                  cnt_d = cnt_q - FADE_W'(1);
                  if (cnt_q == FADE_W'(1)) begin
                     fade_bit_d = 1'b0;
                     state_d    = ST_FADED;
                  end
               end
            end
            ST_FADED: begin
               if (set_now) begin
                  cnt_d   = CNT_LOAD;
                  state_d = ST_DRIVEN;
               end
            end
            default: state_d = ST_FADED;
         endcase
      end

      assign pin_hi[g] = (state_q == ST_DRIVEN) ? dat_q[6+g] : fade_bit_q;
   end

   always_comb begin
      pin      = (ddr_q[5:0] & dat_q[5:0]) | (~ddr_q[5:0] & port_in);
      data_oe  = rw_n & ((addr == 16'h0000) | (addr == 16'h0001));
      data_out = '0;
      if (data_oe) data_out = addr[0] ? {pin_hi, pin} : ddr_q;
   end

   assign port_out   = dat_q[5:0];
   assign port_oe    = ddr_q[5:0];
   assign loram      = pin[0];
   assign hiram      = pin[1];
   assign charen     = pin[2];
   assign cass_wr    = pin[3];
   assign cass_motor = pin[5];

endmodule

// File: doc/cpu_io_port.md
Name: cpu_io_port

Overview:
- Cycle-accurate model of the 6510 on-chip I/O port: data-direction register at $0000, data register at $0001.
- Sits directly upstream of the memory-map PLA and produces its LORAM, HIRAM and CHAREN inputs.
- Also produces the datasette write and motor lines and the CPU read data for $0000/$0001.
- Models the capacitive fade of unconnected bits 6/7 when they are switched to input.

Parameters:
FADE_CYCLES, 350000, number of phi2_en strobes a floating bit 6/7 retains its last driven value after becoming an input
FADE_W, 20, width of each fade counter; must hold FADE_CYCLES

Ports:
clk  input  1  system clock
rst_n  input  1  synchronous active-low reset
phi2_en  input  1  one-clk strobe marking end of a CPU bus cycle (write commit point)
addr  input  16  CPU address bus
rw_n  input  1  CPU read/write, 1 = read
data_in  input  8  CPU write data
port_in  input  6  external pin levels for bits 5:0 (board pull-ups on 0-2 and 4)
data_out  output  8  read data for $0000/$0001
data_oe  output  1  port drives data bus this cycle (overrides RAM read)
port_out  output  6  data register bits 5:0 to pad drivers
port_oe  output  6  DDR bits 5:0 (1 = output)
loram  output  1  effective pin 0 to PLA
hiram  output  1  effective pin 1 to PLA
charen  output  1  effective pin 2 to PLA
cass_wr  output  1  effective pin 3
cass_motor  output  1  effective pin 5

Behaviour:
- Reset (rst_n=0 at clk edge):
  - ddr=0x00, dat=0x00, both fade counters=0, fade_bit[7:6]=0.
  - Reset has priority over any write in the same cycle.
  - After reset all bits are inputs, so loram/hiram/charen follow port_in (1 with pull-ups).
- Write commit, on a clk edge with phi2_en=1 and rw_n=0:
  - addr==16'h0000: ddr<=data_in.
  - addr==16'h0001: dat<=data_in.
  - All other addresses have no effect.
  - Writes without phi2_en are ignored.
  - New values are visible on outputs one clk after the commit edge.
- Effective pin value, bits 0-5: pin[i] = ddr[i] ? dat[i] : port_in[i].
  - loram=pin[0], hiram=pin[1], charen=pin[2], cass_wr=pin[3], cass_motor=pin[5].
  - port_out=dat[5:0], port_oe=ddr[5:0].
- Read path (combinational):
  - data_oe = rw_n & (addr==0 | addr==1).
  - addr 0: data_out=ddr.
  - addr 1: data_out[5:0]=pin[5:0]; data_out[i] for i=6,7 is ddr[i] ? dat[i] : fade_bit[i].
  - data_out=0x00 when data_oe=0.
- Fade FSM, one instance per bit 6 and bit 7:
  - DRIVEN (ddr[i]=1): every clk, fade_bit[i]<=dat[i] and cnt<=FADE_CYCLES.
  - DRIVEN -> FADING when ddr[i] is cleared. The counter holds FADE_CYCLES and fade_bit holds the last driven value.
  - FADING (ddr[i]=0, cnt>0): cnt decrements on each phi2_en. The decrement that takes cnt from 1 to 0 also clears fade_bit[i], entering FADED.
  - FADED (cnt=0): fade_bit[i]=0; stays until ddr[i] is set.
  - Writing dat while a bit is an input does not refresh fade_bit or cnt.
  - A DDR write that sets the bit takes priority over a same-cycle decrement.
  - The counter saturates at 0 and never wraps.
- No other state. Outputs are combinational from registers and port_in.

Test Plan:
- Reset with port_in=6'h3F -> loram=hiram=charen=1, cass_wr=1, cass_motor=1, read $0001 returns 0x3F, read $0000 returns 0x00, data_oe=1 on both.
- Write $0000=0x2F then $0001=0x35 (each with phi2_en), port_in=6'h2F (bit4 low) -> loram=1, hiram=0, charen=1, cass_wr=0, cass_motor=1; read $0001 returns 0x25.
- Write $0001=0x00 with rw_n=0 but phi2_en=0 -> dat unchanged. Write $0002=0xFF with phi2_en=1 -> no change. Read $0002 -> data_oe=0, data_out=0x00.
- FADE_CYCLES=4: write ddr=0xC0, dat=0xC0, then ddr=0x00 -> read $0001 bits 7:6 stay 2'b11 for 3 phi2_en strobes and read 2'b00 from the 4th strobe onward. Writing dat=0x00 during FADING does not change bits 7:6.
- FADE_CYCLES=4, during FADING after 2 strobes write ddr=0x40 -> bit6 DRIVEN with dat[6]=1, counter reloads; bit7 continues fading and reads 0 after 2 more strobes.
- Assert rst_n=0 on the same edge as a phi2_en write of $0001=0xFF -> dat=0x00, ddr=0x00, fade counters 0, and read $0001 bits 7:6 = 0.
